// File: rtl/video_fetch_if.sv
// video_fetch_if: pixel enable, screen/font RAM read ports and video outputs
interface video_fetch_if;
  logic       pix_ce;
  logic [9:0] scr_a;
  logic [7:0] scr_d;
  logic [9:0] font_a;
  logic [7:0] font_d;
  logic       pixel;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic       frame_int;
  modport master (
    input  pix_ce, scr_d, font_d,
    output scr_a, font_a, pixel, active, hsync, vsync, frame_int
  );
  modport slave (
    output pix_ce, scr_d, font_d,
    input  scr_a, font_a, pixel, active, hsync, vsync, frame_int
  );
endinterface

// File: rtl/video_fetch.sv
// video_fetch: character-cell video fetcher with raster timing and sync generation
module video_fetch #(
  parameter int H_TOTAL      = 448,
  parameter int V_TOTAL      = 312,
  parameter int H_SYNC_START = 320,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_SYNC_START = 248,
  parameter int V_SYNC_LEN   = 8
) (
  input logic clk,
  input logic reset,
  video_fetch_if.master v
);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  logic [HW-1:0] hc, hc_n;
  logic [VW-1:0] vc, vc_n;
  logic [7:0] row, shifter;
  logic [2:0] ph;
  logic inv, hwrap, win;
  // next raster position, and whether the current position lies in the fetch window
  always_comb begin
    hwrap = hc == HW'(H_TOTAL - 1);
    hc_n = hwrap ? '0 : hc + HW'(1);
    vc_n = !hwrap ? vc : (vc == VW'(V_TOTAL - 1)) ? '0 : vc + VW'(1);
    win = hc < HW'(256) && vc < VW'(192);
    ph = hc[2:0];
  end
  // raster counters, cell fetch pipeline, pixel shifter; flags are registered from the next position so they line up with the counters
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hc <= '0;
      vc <= '0;
      inv <= 1'b0;
      row <= '0;
      shifter <= '0;
      v.scr_a <= '0;
      v.font_a <= '0;
      v.active <= 1'b0;
      v.hsync <= 1'b0;
      v.vsync <= 1'b0;
      v.frame_int <= 1'b0;
    end else begin
      v.frame_int <= v.pix_ce && hwrap && vc == VW'(191);
      if (v.pix_ce) begin
        hc <= hc_n;
        vc <= vc_n;
        v.active <= hc_n >= HW'(8) && hc_n <= HW'(263) && vc_n < VW'(192);
        v.hsync <= hc_n >= HW'(H_SYNC_START) && hc_n < HW'(H_SYNC_START + H_SYNC_LEN);
        v.vsync <= vc_n >= VW'(V_SYNC_START) && vc_n < VW'(V_SYNC_START + V_SYNC_LEN);
        if (win && ph == 3'd0) v.scr_a <= {vc[7:3], hc[7:3]};
        if (win && ph == 3'd1) begin
          inv <= v.scr_d[7];
          v.font_a <= {v.scr_d[6:0], vc[2:0]};
        end
        if (win && ph == 3'd2) row <= v.font_d;
        shifter <= (win && ph == 3'd7) ? row ^ {8{inv}} : {shifter[6:0], 1'b0};
      end
    end
  assign v.pixel = shifter[7];
endmodule

// File: tb/tb_video_fetch.sv
// tb_video_fetch: random screen/font contents checked against a raster-position reference model
module tb_video_fetch;
  localparam int H = 272;
  localparam int V = 196;
  localparam int HS = 264;
  localparam int HL = 6;
  localparam int VS = 193;
  localparam int VL = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] scr [1024];
  logic [7:0] font [1024];
  int n = 0;
  int tests = 0;
  int fails = 0;
  int fi_cnt = 0;
  video_fetch_if vif();
  video_fetch #(
    .H_TOTAL(H), .V_TOTAL(V),
    .H_SYNC_START(HS), .H_SYNC_LEN(HL),
    .V_SYNC_START(VS), .V_SYNC_LEN(VL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .v(vif)
  );
  always #5 clk = ~clk;
  // synchronous-read RAMs clocked on the falling edge: data for an address issued at one rising edge is ready by the next
  always @(negedge clk) begin
    vif.scr_d <= scr[vif.scr_a];
    vif.font_d <= font[vif.font_a];
  end
  function automatic logic exp_pix(int hc, int vc);
    int c, b;
    logic [7:0] s, f;
    if (vc >= 192 || hc < 8 || hc > 263) return 1'b0;
    c = (hc - 8) / 8;
    b = (hc - 8) % 8;
    s = scr[10'((vc / 8) * 32 + c)];
    f = font[10'(int'(s[6:0]) * 8 + vc % 8)] ^ (s[7] ? 8'hff : 8'h00);
    return f[3'(7 - b)];
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(logic ce);
    int hc, vc;
    logic fi;
    vif.pix_ce = ce;
    @(posedge clk);
    if (ce && !reset) n++;
    hc = n % H;
    vc = (n / H) % V;
    fi = ce && !reset && hc == 0 && vc == 192;
    #1;
    chk("pixel", 32'(vif.pixel), 32'(exp_pix(hc, vc)));
    chk("active", 32'(vif.active), 32'(hc >= 8 && hc <= 263 && vc < 192));
    chk("hsync", 32'(vif.hsync), 32'(hc >= HS && hc < HS + HL));
    chk("vsync", 32'(vif.vsync), 32'(vc >= VS && vc < VS + VL));
    chk("frame_int", 32'(vif.frame_int), 32'(fi));
    chk("scr_a_range", 32'(vif.scr_a <= 10'd767), 32'd1);
    if (vif.frame_int) fi_cnt++;
    if (vc >= 184 && vc < 192 && hc == 252) chk("scr_a_767", 32'(vif.scr_a), 32'd767);
    if (vc == 0 && hc == 4) chk("font_a_028", 32'(vif.font_a), 32'h028);
    if (vc == 0 && hc >= 8 && hc < 16) chk("cell0_inverse", 32'(vif.pixel), 32'(hc < 12));
    if (vc == 0 && hc >= 16 && hc < 24) chk("cell1_81", 32'(vif.pixel), 32'(hc == 16 || hc == 23));
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_pixel"}, 32'(vif.pixel), 32'd0);
    chk({tag, "_active"}, 32'(vif.active), 32'd0);
    chk({tag, "_hsync"}, 32'(vif.hsync), 32'd0);
    chk({tag, "_vsync"}, 32'(vif.vsync), 32'd0);
    chk({tag, "_frame_int"}, 32'(vif.frame_int), 32'd0);
    chk({tag, "_scr_a"}, 32'(vif.scr_a), 32'd0);
    chk({tag, "_font_a"}, 32'(vif.font_a), 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) begin
      scr[i] = 8'($urandom);
      font[i] = 8'($urandom);
    end
    scr[0] = 8'h85;
    font[40] = 8'h0f;
    scr[1] = 8'h00;
    font[0] = 8'h81;
    vif.pix_ce = 1'b0;
    repeat (3) step(1'b1);
    chk_zero("reset");
    #2 reset = 1'b0;
    repeat (300) step(1'b1);
    repeat (200) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
    end
    while (n < H * V + 20) step(1'b1);
    chk("frame_int_count", 32'(fi_cnt), 32'd1);
    while (n != H * V + 100 * H + 130) step(1'b1);
    chk("pre_reset_active", 32'(vif.active), 32'd1);
    #2 reset = 1'b1;
    n = 0;
    #1 chk_zero("mid_reset");
    repeat (3) step(1'b1);
    chk_zero("held_reset");
    #2 reset = 1'b0;
    repeat (600) step(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/video_fetch.md
VIDEO_FETCH -- requirements
Module: video_fetch

Interface
REQ-001 Parameter H_TOTAL, default 448, pixel clocks per line.
REQ-002 Parameter V_TOTAL, default 312, lines per frame.
REQ-003 Parameter H_SYNC_START, default 320, and H_SYNC_LEN, default 32: hsync window in hc.
REQ-004 Parameter V_SYNC_START, default 248, and V_SYNC_LEN, default 8: vsync window in vc.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 pix_ce  in  1  pixel enable; counters and pipeline advance only on clk edges with pix_ce=1.
REQ-008 scr_a  out  10  screen RAM read address (synchronous-read RAM, 1-clk latency).
REQ-009 scr_d  in  8  screen RAM read data: bit7 inverse, bits6:0 char code.
REQ-010 font_a  out  10  character-set RAM read address (1-clk latency).
REQ-011 font_d  in  8  character-set row data, bit7 = leftmost pixel.
REQ-012 pixel  out  1  video pixel, 1 = ink.
REQ-013 active  out  1  high while pixel is inside the 256x192 display area.
REQ-014 hsync, vsync  out  1 each  active-high sync.
REQ-015 frame_int  out  1  one-clk pulse at start of vertical blanking.

Function
REQ-016 hc counts 0..H_TOTAL-1 per pix_ce; at H_TOTAL-1 wraps to 0 and vc increments.
REQ-017 vc counts 0..V_TOTAL-1; at vc=V_TOTAL-1 with hc wrap, vc wraps to 0.
REQ-018 Fetch window: vc<192 and hc<256; cell col=hc[7:3], phase=hc[2:0].
REQ-019 Phase 0: scr_a = {vc[7:3], col} (max 767); held until next phase 0 in window.
REQ-020 Phase 1: capture scr_d into code register; font_a = {scr_d[6:0], vc[2:0]}; held.
REQ-021 Phase 2: capture font_d into row register.
REQ-022 Phase 7: load 8-bit shifter with row register XOR {8{code[7]}}.
REQ-023 Other pix_ce edges: shifter shifts left, zero filled; pixel = shifter[7].
REQ-024 Outside fetch window no load occurs; shifter drains to 0 within 8 pix_ce, so pixel=0 in blanking.
REQ-025 Pixel for cell c appears on hc = 8c+8 .. 8c+15 (fixed 8-pixel lag).
REQ-026 active=1 iff 8<=hc<=263 and vc<192, registered and aligned with pixel.
REQ-027 hsync=1 iff H_SYNC_START<=hc<H_SYNC_START+H_SYNC_LEN; vsync likewise on vc.
REQ-028 frame_int=1 for exactly one clk on the pix_ce edge where vc becomes 192 at hc=0.
REQ-029 pix_ce=0: all registers and addresses hold; sustained pix_ce=1 every clk is supported.
REQ-030 Read addresses are pure functions of registered state; no combinational path from scr_d/font_d to any output except via registers.

Reset
REQ-031 reset=1 immediately clears hc, vc, code, row, shifter; scr_a=0, font_a=0.
REQ-032 During reset pixel=0, active=0, hsync=0, vsync=0, frame_int=0.
REQ-033 Reset mid-line or mid-frame restarts at hc=0, vc=0 on first pix_ce after release; no partial cell is output.

Verification
REQ-034 Reset release, pix_ce=1 every clk, screen RAM all 0x00, font row 0x81 -> per cell pixel pattern 1,0,0,0,0,0,0,1 starting hc=8; active high hc 8..263.
REQ-035 Screen byte 0x85 at address 0 (inverse, code 5), font[5*8+0]=0x0F -> row 0 cell 0 pixels 1,1,1,1,0,0,0,0; font_a observed 0x028.
REQ-036 Cell row 23 col 31 -> scr_a=767 at hc=248 on vc=184..191; no scr_a >767 ever.
REQ-037 Run full frame -> hsync 32 clk per line at hc 320..351, vsync lines 248..255, one frame_int pulse per 448*312 pix_ce.
REQ-038 pix_ce toggling 1-of-3 clks -> identical pixel sequence to REQ-034 at one third rate; outputs stable between enables.
REQ-039 Assert reset at vc=100, hc=130 -> outputs zero immediately; after release first active pixel at hc=8, vc=0.
